rca_config_sequencer: RTL and testbench
=======================================

# rca_config_sequencer

Sequences RCA configuration instructions (fn7 CPU_REG_CONFIG … IO_INP_MAP_CONFIG, fn3 = target RCA index) from the RCA issue path onto the shared configuration bus of the reconfigurable grid.

- Buffers config writes in an in-order queue and drains them one at a time.
- Holds off a write while its target RCA is executing.
- Gates USE_FB/USE_NFB issue for any RCA with configuration still pending.
- Sits between decode/issue and the RCA grid.

## Interface

Parameters:
- NUM_RCAS, 4: number of RCAs addressable by fn3; legal range 1..8.
- FIFO_DEPTH, 4: config queue entries; power of two, ≥2.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset: one clock, synchronous, active-high.
- req_valid  in  1  config request presented.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_fn7  in  7  rca_fn7_t opcode field.
- req_rca_sel  in  3  fn3, target RCA.
- req_rs1  in  32  config address/selector operand.
- req_rs2  in  32  config data operand.
- req_done  out  1  one-cycle pulse: legal request enqueued (retire, no rd write).
- illegal  out  1  one-cycle pulse: request rejected.
- cfg_valid  out  1  config write presented to grid.
- cfg_ready  in  1  grid accepts the write.
- cfg_rca_sel  out  3  target RCA.
- cfg_type  out  3  rca_cfg_type_t.
- cfg_addr  out  32  rs1 of entry.
- cfg_data  out  32  rs2 of entry.
- rca_busy  in  NUM_RCAS  RCA k executing a USE instruction.
- use_allowed  out  NUM_RCAS  RCA k has no pending config; issue may send USE to k.

## Operation

- **Request legality:** fn7 must be one of 0b0000010..0b0000110 and req_rca_sel < NUM_RCAS. Otherwise:
  - the request is consumed (ready rules unchanged) and illegal pulses;
  - nothing is enqueued and counters are unchanged.
- **cfg_type:** fn7 − 2, i.e. CPU_REG=0, GRID_MUX=1, IO_MUX=2, RESULT_MUX=3, IO_INP_MAP=4.
- **Enqueue:** a legal accepted request pushes {sel, type, rs1, rs2} to the queue tail and increments pending[sel].
- **Drain:** strictly in order from the head.
  - cfg_valid = !empty && !rca_busy[head.sel]. A busy head blocks all later entries.
  - cfg_* fields come from the registered head entry and are stable while cfg_valid && !cfg_ready.
  - On cfg_valid && cfg_ready: pop, and decrement pending[head.sel].
- **Issue gating:** use_allowed[k] = (pending[k] == 0). Because of this, rca_busy[head.sel] cannot rise while the head waits, so a cfg_valid, once raised, never drops before its handshake.
- **Simultaneous push and pop:**
  - Occupancy is unchanged.
  - If push and pop target the same RCA, pending is unchanged; otherwise one counter increments and the other decrements.
- **Counter width:** pending counters are clog2(FIFO_DEPTH+1) bits and never exceed FIFO_DEPTH. Wrap is impossible by construction; an assertion checks it.
- **Pointers:** read and write pointers wrap modulo FIFO_DEPTH. full/empty are derived from an occupancy count.

## Timing

- **Reset values:** req_ready=1, req_done=0, illegal=0, cfg_valid=0, cfg_rca_sel/cfg_type/cfg_addr/cfg_data=0, use_allowed=all 1. The queue is emptied and all pending counters are cleared.
- **Reset mid-operation:** queued configs are discarded. use_allowed returns to all-1 the cycle after rst.
- **req_ready:** equals !full, from registered state. There is no same-cycle bypass, so a full queue with a pop this cycle still shows req_ready=0.
- **Latency, request accepted in cycle N:**
  - req_done or illegal pulses in N+1 (registered).
  - The entry is visible at the head, with cfg_valid possibly high, in N+1 if the queue was empty and the RCA is not busy.
  - use_allowed[sel] falls in N+1.
- **Handshake in cycle M:** the next entry appears in M+1. use_allowed[sel] rises in M+1 if its pending count reached 0.
- **Throughput:** 1 config/cycle sustained, with cfg_ready=1 and no busy RCAs.

## Structure

- Shared package (alongside the RCA opcode types):
  - rca_cfg_type_t (3-bit enum above);
  - rca_cfg_entry_t packed struct {sel[2:0], type, addr[31:0], data[31:0]};
  - constants RCA_CFG_FN7_MIN=2 and RCA_CFG_FN7_MAX=6.
- One sub-module, rca_cfg_fifo: a parameterized first-word-fall-through queue of rca_cfg_entry_t with push, pop, full, empty.
- The top level holds legality decode, pending counters, drain gating and the output pulses.

## Test plan

- **Single write:** fn7=3, sel=2, rs1=0x10, rs2=0xABCD, cfg_ready=1 at N → in N+1: cfg_valid=1, sel=2, type=1, addr=0x10, data=0xABCD, req_done=1, use_allowed[2]=0. In N+2: use_allowed=4'b1111.
- **Head-of-line blocking:** rca_busy[1]=1; enqueue sel=1 then sel=0 → cfg_valid stays 0 and use_allowed=4'b1100. Drop busy → the sel=1 write, then the sel=0 write, on consecutive cycles; use_allowed=4'b1111 the following cycle.
- **Full queue:** FIFO_DEPTH=4, cfg_ready=0, five back-to-back requests → req_ready=0 after the 4th accept and the 5th is held. One handshake → req_ready=1 the next cycle and the 5th is accepted.
- **Illegal requests:** fn7=0 (USE_FB) → illegal pulse, no enqueue. fn7=2 with sel=5 (NUM_RCAS=4) → illegal pulse, no enqueue. use_allowed unchanged in both cases.
- **Backpressure:** cfg_ready=0 for 3 cycles with a valid head → cfg_* bit-identical across all 3 cycles and cfg_valid held at 1.
- **Reset mid-operation:** 3 entries queued with cfg_ready=0, then rst for 1 cycle → next cycle: cfg_valid=0, req_ready=1, use_allowed=4'b1111, and no stale write appears afterward.

Source files
------------

// File: rtl/rca_config_sequencer_pkg.sv
// rca_config_sequencer_pkg: RCA opcode and configuration-entry types shared by issue, sequencer and grid
package rca_config_sequencer_pkg;

    typedef enum logic [6:0] {
        USE_FB            = 7'd0,
        USE_NFB           = 7'd1,
        CPU_REG_CONFIG    = 7'd2,
        GRID_MUX_CONFIG   = 7'd3,
        IO_MUX_CONFIG     = 7'd4,
        RESULT_MUX_CONFIG = 7'd5,
        IO_INP_MAP_CONFIG = 7'd6
    } rca_fn7_t;

    typedef enum logic [2:0] {
        CFG_CPU_REG    = 3'd0,
        CFG_GRID_MUX   = 3'd1,
        CFG_IO_MUX     = 3'd2,
        CFG_RESULT_MUX = 3'd3,
        CFG_IO_INP_MAP = 3'd4
    } rca_cfg_type_t;

    typedef struct packed {
        logic [2:0]    sel;
        rca_cfg_type_t cfg_type;
        logic [31:0]   addr;
        logic [31:0]   data;
    } rca_cfg_entry_t;

    localparam logic [6:0] RCA_CFG_FN7_MIN = 7'd2;
    localparam logic [6:0] RCA_CFG_FN7_MAX = 7'd6;

    function automatic logic is_cfg_fn7(input logic [6:0] fn7);
        return (fn7 >= RCA_CFG_FN7_MIN) && (fn7 <= RCA_CFG_FN7_MAX);
    endfunction

    function automatic rca_cfg_type_t fn7_to_cfg_type(input logic [6:0] fn7);
        return rca_cfg_type_t'(3'(fn7 - RCA_CFG_FN7_MIN));
    endfunction

endpackage

// File: rtl/rca_config_sequencer_if.sv
// rca_config_sequencer_if: issue-side config requests, grid config bus and per-RCA busy/issue status
interface rca_config_sequencer_if #(
    parameter int NUM_RCAS = 4
);
    logic                req_valid;
    logic                req_ready;
    logic [6:0]          req_fn7;
    logic [2:0]          req_rca_sel;
    logic [31:0]         req_rs1;
    logic [31:0]         req_rs2;
    logic                req_done;
    logic                illegal;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [2:0]          cfg_rca_sel;
    logic [2:0]          cfg_type;
    logic [31:0]         cfg_addr;
    logic [31:0]         cfg_data;
    logic [NUM_RCAS-1:0] rca_busy;
    logic [NUM_RCAS-1:0] use_allowed;

    modport slave (
        input  req_valid, req_fn7, req_rca_sel, req_rs1, req_rs2, cfg_ready, rca_busy,
        output req_ready, req_done, illegal, cfg_valid, cfg_rca_sel, cfg_type, cfg_addr, cfg_data,
               use_allowed
    );

    modport master (
        output req_valid, req_fn7, req_rca_sel, req_rs1, req_rs2, cfg_ready, rca_busy,
        input  req_ready, req_done, illegal, cfg_valid, cfg_rca_sel, cfg_type, cfg_addr, cfg_data,
               use_allowed
    );

endinterface

// File: rtl/rca_cfg_fifo.sv
// rca_cfg_fifo: first-word-fall-through in-order queue of RCA configuration entries
module rca_cfg_fifo
    import rca_config_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  rca_cfg_entry_t push_data,
    output rca_cfg_entry_t head,
    output logic           full,
    output logic           empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    rca_cfg_entry_t mem_q [DEPTH];
    rca_cfg_entry_t mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign head  = mem_q[rd_ptr_q];

    // Write at the tail, advance wrapping pointers, track occupancy for full/empty
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = push_data;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Storage is cleared on reset so the head reads as zero while empty after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The sequencer never pushes into a full queue nor pops an empty one
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full));
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/rca_config_sequencer.sv
// rca_config_sequencer: queues RCA config writes, drains them in order onto the grid config bus, gates USE issue
module rca_config_sequencer
    import rca_config_sequencer_pkg::*;
#(
    parameter int NUM_RCAS   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    rca_config_sequencer_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    rca_cfg_entry_t      push_entry;
    rca_cfg_entry_t      head;
    logic                full, empty;
    logic                legal, accept, push, pop;
    logic                head_busy;
    logic [NUM_RCAS-1:0] head_onehot;
    logic                req_done_q, req_done_d;
    logic                illegal_q, illegal_d;
    logic [CW-1:0]       pending_q [NUM_RCAS];
    logic [CW-1:0]       pending_d [NUM_RCAS];

    rca_cfg_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .push_data(push_entry),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    // Legality decode, enqueue and drain handshakes; a busy head RCA stalls the whole queue
    always_comb begin
        legal               = is_cfg_fn7(bus.req_fn7) && ({29'd0, bus.req_rca_sel} < 32'(NUM_RCAS));
        accept              = bus.req_valid && !full;
        push                = accept && legal;
        push_entry.sel      = bus.req_rca_sel;
        push_entry.cfg_type = fn7_to_cfg_type(bus.req_fn7);
        push_entry.addr     = bus.req_rs1;
        push_entry.data     = bus.req_rs2;
        for (int k = 0; k < NUM_RCAS; k++) head_onehot[k] = head.sel == 3'(k);
        head_busy           = |(bus.rca_busy & head_onehot);
        pop                 = !empty && !head_busy && bus.cfg_ready;
        req_done_d          = push;
        illegal_d           = accept && !legal;
    end

    // Per-RCA pending counts: enqueue and drain to the same RCA in one cycle cancel out
    always_comb begin
        for (int k = 0; k < NUM_RCAS; k++)
            pending_d[k] = pending_q[k] + CW'(push && bus.req_rca_sel == 3'(k))
                                        - CW'(pop && head.sel == 3'(k));
    end

    // Issue may send USE to an RCA only once none of its config writes are outstanding
    always_comb begin
        for (int k = 0; k < NUM_RCAS; k++) bus.use_allowed[k] = pending_q[k] == '0;
    end

    assign bus.req_ready   = !full;
    assign bus.req_done    = req_done_q;
    assign bus.illegal     = illegal_q;
    assign bus.cfg_valid   = !empty && !head_busy;
    assign bus.cfg_rca_sel = head.sel;
    assign bus.cfg_type    = head.cfg_type;
    assign bus.cfg_addr    = head.addr;
    assign bus.cfg_data    = head.data;

    // Registered retire/reject pulses and pending counters
    always_ff @(posedge clk) begin
        if (rst) begin
            req_done_q <= 1'b0;
            illegal_q  <= 1'b0;
            for (int k = 0; k < NUM_RCAS; k++) pending_q[k] <= '0;
        end else begin
            req_done_q <= req_done_d;
            illegal_q  <= illegal_d;
            pending_q  <= pending_d;
        end
    end

    // A pending count can never exceed the queue depth, so it cannot wrap either way
    always_ff @(posedge clk) begin
        if (!rst)
            for (int k = 0; k < NUM_RCAS; k++) assert (pending_d[k] <= CW'(FIFO_DEPTH));
    end

endmodule

// File: tb/tb_rca_config_sequencer.sv
// tb_rca_config_sequencer: scoreboard bench for the RCA config sequencer (NUM_RCAS=4, FIFO_DEPTH=4)
module tb_rca_config_sequencer;

    typedef struct {
        logic [2:0]  sel;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_en = 1'b0;
    logic exp_done = 1'b0;
    logic exp_ill = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   pend [4];
    exp_t sb [$];

    rca_config_sequencer_if #(.NUM_RCAS(4)) bus ();

    rca_config_sequencer #(
        .NUM_RCAS  (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [6:0] f, input logic [2:0] s);
        return f >= 7'd2 && f <= 7'd6 && s < 3'd4;
    endfunction

    function automatic logic [3:0] exp_use();
        logic [3:0] u;
        for (int k = 0; k < 4; k++) u[k] = pend[k] == 0;
        return u;
    endfunction

    // Scoreboard monitor: checks registered outputs mid-cycle, then models the coming edge
    always @(negedge clk) begin
        exp_t e;
        logic hv;
        if (mon_en) begin
            hv = sb.size() != 0 && !bus.rca_busy[sb[0].sel[1:0]];
            check("req_ready", bus.req_ready, sb.size() < 4);
            check("req_done", bus.req_done, exp_done);
            check("illegal", bus.illegal, exp_ill);
            check("use_allowed", bus.use_allowed, exp_use());
            check("cfg_valid", bus.cfg_valid, hv);
            if (hv && bus.cfg_valid) begin
                check("cfg_rca_sel", bus.cfg_rca_sel, sb[0].sel);
                check("cfg_type", bus.cfg_type, sb[0].typ);
                check("cfg_addr", bus.cfg_addr, sb[0].addr);
                check("cfg_data", bus.cfg_data, sb[0].data);
            end
            if (rst) begin
                sb.delete();
                pend = '{default: 0};
                exp_done = 1'b0;
                exp_ill = 1'b0;
            end else begin
                if (bus.cfg_valid && bus.cfg_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    pend[e.sel[1:0]]--;
                end
                exp_done = bus.req_valid && bus.req_ready && is_legal(bus.req_fn7, bus.req_rca_sel);
                exp_ill = bus.req_valid && bus.req_ready && !is_legal(bus.req_fn7, bus.req_rca_sel);
                if (exp_done) begin
                    e.sel = bus.req_rca_sel;
                    e.typ = 3'(bus.req_fn7 - 7'd2);
                    e.addr = bus.req_rs1;
                    e.data = bus.req_rs2;
                    sb.push_back(e);
                    pend[bus.req_rca_sel[1:0]]++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] f, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid = 1'b1;
        bus.req_fn7 = f;
        bus.req_rca_sel = s;
        bus.req_rs1 = a;
        bus.req_rs2 = d;
    endtask

    task automatic send(input logic [6:0] f, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        drive(f, s, a, d);
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check("send_timeout", 1'b0, 1'b1);
        tick(1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        bus.req_valid = 1'b0;
        bus.rca_busy = 4'b0;
        bus.cfg_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        tick(1);
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1);
    end

    initial begin
        int c0;
        bus.req_valid = 1'b0;
        bus.req_fn7 = '0;
        bus.req_rca_sel = '0;
        bus.req_rs1 = '0;
        bus.req_rs2 = '0;
        bus.cfg_ready = 1'b0;
        bus.rca_busy = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        check("rst_cfg_valid", bus.cfg_valid, 1'b0);
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_use", bus.use_allowed, 4'b1111);
        check("rst_cfg_sel", bus.cfg_rca_sel, 3'd0);
        check("rst_cfg_type", bus.cfg_type, 3'd0);
        check("rst_cfg_addr", bus.cfg_addr, 32'd0);
        check("rst_cfg_data", bus.cfg_data, 32'd0);
        check("rst_done", bus.req_done, 1'b0);
        check("rst_illegal", bus.illegal, 1'b0);

        bus.cfg_ready = 1'b1;
        send(7'd3, 3'd2, 32'h10, 32'hABCD);
        check("sw_valid", bus.cfg_valid, 1'b1);
        check("sw_sel", bus.cfg_rca_sel, 3'd2);
        check("sw_type", bus.cfg_type, 3'd1);
        check("sw_addr", bus.cfg_addr, 32'h10);
        check("sw_data", bus.cfg_data, 32'hABCD);
        check("sw_done", bus.req_done, 1'b1);
        check("sw_use_busy", bus.use_allowed, 4'b1011);
        tick(1);
        check("sw_use_free", bus.use_allowed, 4'b1111);

        bus.rca_busy = 4'b0010;
        send(7'd2, 3'd1, 32'h100, 32'h1);
        send(7'd4, 3'd0, 32'h200, 32'h2);
        check("hol_valid", bus.cfg_valid, 1'b0);
        check("hol_use", bus.use_allowed, 4'b1100);
        tick(2);
        check("hol_valid_held", bus.cfg_valid, 1'b0);
        bus.rca_busy = 4'b0;
        #1;
        check("hol_first_valid", bus.cfg_valid, 1'b1);
        check("hol_first_sel", bus.cfg_rca_sel, 3'd1);
        tick(1);
        check("hol_second_valid", bus.cfg_valid, 1'b1);
        check("hol_second_sel", bus.cfg_rca_sel, 3'd0);
        check("hol_second_type", bus.cfg_type, 3'd2);
        tick(1);
        check("hol_use_free", bus.use_allowed, 4'b1111);
        check("hol_empty", bus.cfg_valid, 1'b0);

        bus.cfg_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(7'(2 + i), 3'(i), 32'(i + 32'h1000), 32'(i * 7));
            tick(1);
        end
        check("full_ready", bus.req_ready, 1'b0);
        drive(7'd6, 3'd0, 32'h5555, 32'h6666);
        tick(2);
        check("full_held", bus.req_ready, 1'b0);
        bus.cfg_ready = 1'b1;
        tick(1);
        bus.cfg_ready = 1'b0;
        check("full_ready_after_pop", bus.req_ready, 1'b1);
        tick(1);
        bus.req_valid = 1'b0;
        check("full_refilled", bus.req_ready, 1'b0);
        drain();

        send(7'd0, 3'd1, 32'h1, 32'h2);
        check("ill_fn7_pulse", bus.illegal, 1'b1);
        check("ill_fn7_done", bus.req_done, 1'b0);
        check("ill_fn7_use", bus.use_allowed, 4'b1111);
        check("ill_fn7_valid", bus.cfg_valid, 1'b0);
        send(7'd2, 3'd5, 32'h3, 32'h4);
        check("ill_sel_pulse", bus.illegal, 1'b1);
        check("ill_sel_use", bus.use_allowed, 4'b1111);
        check("ill_sel_valid", bus.cfg_valid, 1'b0);
        send(7'd7, 3'd0, 32'h5, 32'h6);
        check("ill_fn7_hi_pulse", bus.illegal, 1'b1);
        tick(1);
        check("ill_one_cycle", bus.illegal, 1'b0);

        bus.cfg_ready = 1'b0;
        send(7'd5, 3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", bus.cfg_valid, 1'b1);
            check("bp_sel", bus.cfg_rca_sel, 3'd3);
            check("bp_type", bus.cfg_type, 3'd3);
            check("bp_addr", bus.cfg_addr, 32'hDEAD_BEEF);
            check("bp_data", bus.cfg_data, 32'h1234_5678);
            tick(1);
        end
        bus.cfg_ready = 1'b1;
        tick(1);
        check("bp_use_free", bus.use_allowed, 4'b1111);

        bus.cfg_ready = 1'b0;
        send(7'd2, 3'd0, 32'hA0, 32'hB0);
        send(7'd3, 3'd1, 32'hA1, 32'hB1);
        send(7'd4, 3'd2, 32'hA2, 32'hB2);
        check("mid_use_before", bus.use_allowed, 4'b1000);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_valid", bus.cfg_valid, 1'b0);
        check("mid_rst_ready", bus.req_ready, 1'b1);
        check("mid_rst_use", bus.use_allowed, 4'b1111);
        bus.cfg_ready = 1'b1;
        tick(5);
        check("mid_rst_no_stale", bus.cfg_valid, 1'b0);

        c0 = cyc;
        for (int i = 0; i < 16; i++) send(7'(2 + i % 5), 3'(i % 4), $urandom, $urandom);
        check("tput_cycles", 64'(cyc - c0), 64'd16);
        drain();

        for (int i = 0; i < 80; i++) begin
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_fn7 = 7'($urandom_range(0, 7));
            bus.req_rca_sel = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            bus.req_rs1 = $urandom;
            bus.req_rs2 = $urandom;
            bus.cfg_ready = 1'($urandom_range(0, 1));
            bus.rca_busy = 4'($urandom_range(0, 15)) & bus.use_allowed;
            tick(1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
